// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and helpers for the multi-cycle shift sequencer.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEP  = 4;
  // Wide enough to hold any saturated shift amount 0..WIDTH.
  localparam int SHAMT_W   = $clog2(DEF_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Unsigned minimum, used for amount saturation and per-cycle step size.
  function automatic logic [31:0] min_amt(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_step.sv
// shift_step: combinational shifter covering 0..STEP positions in one pass.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP,
  parameter int K_W   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [K_W-1:0]   k,
  input  logic             is_left,
  input  logic             is_arith,
  output logic [WIDTH-1:0] data_out
);

  // Left is always zero-fill; right fills with the MSB only when arithmetic.
  always_comb begin
    data_out = data;
    if (is_left)       data_out = data << k;
    else if (is_arith) data_out = $signed(data) >>> k;
    else               data_out = data >> k;
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences a wide shift as repeated STEP-sized shifts.
// The accept cycle already performs the first step, so an op of eff_amt
// positions reaches DONE max(1, ceil(eff_amt/STEP)) cycles after accept.
// Optional op counter enabled by defining SHIFT_SEQ_STATS_EN.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_in,
  input  logic [31:0]      req_shamt,
  input  logic             req_is_left,
  input  logic             req_is_arith,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_out,
  output logic             busy
`ifdef SHIFT_SEQ_STATS_EN
  ,output logic [15:0]     op_count
`endif
);

  localparam int REM_W = $clog2(WIDTH) + 1;
  localparam int K_W   = $clog2(STEP) + 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               left_q, left_d;
  logic               arith_q, arith_d;
  logic               rdy_en_q;

  logic               idle, accept;
  logic [REM_W-1:0]   eff, rem_src, rem_after;
  logic [K_W-1:0]     k;
  logic [WIDTH-1:0]   step_in, step_out;
  logic               step_left, step_arith;

  assign idle       = (state_q == IDLE);
  assign req_ready  = idle & rdy_en_q;
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state_q == DONE);
  assign resp_out   = data_q;
  assign busy       = ~idle;

  // Saturate the full 32-bit amount to WIDTH.
  assign eff = REM_W'(min_amt(req_shamt, 32'(WIDTH)));

  // In IDLE the shifter works on the incoming request; afterwards on the held op.
  assign rem_src    = idle ? eff          : rem_q;
  assign step_in    = idle ? req_in       : data_q;
  assign step_left  = idle ? req_is_left  : left_q;
  assign step_arith = idle ? req_is_arith : arith_q;
  assign k          = K_W'(min_amt(32'(rem_src), 32'(STEP)));
  assign rem_after  = rem_src - REM_W'(k);

  shift_step #(.WIDTH(WIDTH), .STEP(STEP), .K_W(K_W)) u_step (
    .data     (step_in),
    .k        (k),
    .is_left  (step_left),
    .is_arith (step_arith),
    .data_out (step_out)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    left_d  = left_q;
    arith_d = arith_q;
    case (state_q)
      IDLE: if (accept) begin
        data_d  = step_out;
        rem_d   = rem_after;
        left_d  = req_is_left;
        arith_d = req_is_arith;
        state_d = (rem_after == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        data_d = step_out;
        rem_d  = rem_after;
        if (rem_after == '0) state_d = DONE;
      end
      DONE: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and operand registers; rdy_en_q holds req_ready low during the reset cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      rem_q    <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
      rdy_en_q <= 1'b1;
    end
  end

`ifdef SHIFT_SEQ_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Count response handshakes; wraps naturally at 16 bits.
  always_comb cnt_d = cnt_q + 16'(resp_valid & resp_ready);

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign op_count = cnt_q;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: scoreboard bench for shift_seq_ctrl (WIDTH=32, STEP=4).
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_left, req_is_arith;
  logic [31:0] req_in, req_shamt;
  logic        resp_valid, resp_ready, busy;
  logic [31:0] resp_out;
`ifdef SHIFT_SEQ_STATS_EN
  logic [15:0] op_count;
  int          ops_done = 0;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  shift_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_in       (req_in),
    .req_shamt    (req_shamt),
    .req_is_left  (req_is_left),
    .req_is_arith (req_is_arith),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_out     (resp_out),
    .busy         (busy)
`ifdef SHIFT_SEQ_STATS_EN
    ,.op_count    (op_count)
`endif
  );

  // Reference behaviour of a full shift.
  function automatic logic [31:0] model(input logic [31:0] in, input logic [31:0] sh,
                                        input logic l, input logic a);
    if (sh >= 32) return (!l && a && in[31]) ? 32'hFFFF_FFFF : 32'h0;
    if (l) return in << sh;
    if (a) return $signed(in) >>> sh;
    return in >> sh;
  endfunction

  function automatic int model_lat(input logic [31:0] sh);
    int eff;
    eff = (sh >= 32) ? 32 : int'(sh);
    return (eff == 0) ? 1 : (eff + 3) / 4;
  endfunction

  // Wait for req_ready, present one request, record expectations; returns #1 after accept edge.
  task automatic send(input logic [31:0] in, input logic [31:0] sh, input logic l,
                      input logic a, input logic [31:0] exp, input int lat);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_in = in; req_shamt = sh; req_is_left = l; req_is_arith = a;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    @(posedge clk); #1;
    // Scramble request inputs after accept; the op in flight must not notice.
    req_valid = 1'b0; req_in = $urandom; req_shamt = $urandom;
    req_is_left = 1'($urandom); req_is_arith = 1'($urandom);
  endtask

  // Wait (bounded) for a response, take it, report data and cycles since accept.
  task automatic recv(output logic [31:0] got, output int lat);
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!resp_valid) begin got = 'x; lat = -1; return; end
    got = resp_out;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
`ifdef SHIFT_SEQ_STATS_EN
    ops_done++;
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_in = '0; req_shamt = '0; req_is_left = 1'b0; req_is_arith = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, busy, resp_out} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b out=%h required all 0",
               req_ready, resp_valid, busy, resp_out);
    end
`ifdef SHIFT_SEQ_STATS_EN
    checks++;
    if (op_count !== 16'd0) begin errors++; $display("FAIL reset_opcount: %0d required 0", op_count); end
`endif
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early: %b required 0", req_ready); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: %b required 1", req_ready); end
  endtask

  task automatic test_directed;
    logic [31:0] t_in[13] = '{32'd6541, 32'd6541, 32'd6541, 32'hFFFFFFC0, 32'hFFFFFFC0,
                              32'hFFFFFFC0, 32'hFFFFFFC0, 32'hFFFFFFC0, 32'd6541, 32'hFFFFFFC0,
                              32'h80000001, 32'h12345678, 32'h12345678};
    logic [31:0] t_sh[13] = '{3, 3, 3, 3, 3, 3, 40, 40, 0, 32'hFFFFFFFF, 32, 5, 4};
    logic        t_l[13]  = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1};
    logic        t_a[13]  = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0};
    logic [31:0] t_e[13]  = '{32'd52328, 32'd817, 32'd817, 32'h1FFFFFF8, 32'hFFFFFFF8,
                              32'hFFFFFE00, 32'hFFFFFFFF, 32'h0, 32'd6541, 32'h0,
                              32'hFFFFFFFF, 32'h0091A2B3, 32'h23456780};
    int          t_lat[13] = '{1, 1, 1, 1, 1, 1, 8, 8, 1, 8, 8, 2, 1};
    logic [31:0] got, exp;
    int          lat, elat;
    for (int i = 0; i < 13; i++) begin
      send(t_in[i], t_sh[i], t_l[i], t_a[i], t_e[i], t_lat[i]);
      recv(got, lat);
      exp = exp_q.pop_front(); elat = lat_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL directed_%0d data: got %h required %h", i, got, exp); end
      checks++;
      if (lat !== elat) begin errors++; $display("FAIL directed_%0d latency: got %0d required %0d", i, lat, elat); end
    end
  endtask

  task automatic test_random;
    logic [31:0] in, sh, got, exp;
    logic        l, a;
    int          lat, elat;
    for (int i = 0; i < 20; i++) begin
      in = $urandom; l = 1'($urandom); a = 1'($urandom);
      sh = (i % 5 == 4) ? $urandom : 32'($urandom_range(0, 40));
      send(in, sh, l, a, model(in, sh, l, a), model_lat(sh));
      recv(got, lat);
      exp = exp_q.pop_front(); elat = lat_q.pop_front();
      checks++;
      if (got !== exp || lat !== elat) begin
        errors++;
        $display("FAIL random_%0d: in=%h sh=%0d l=%b a=%b got %h/%0d required %h/%0d",
                 i, in, sh, l, a, got, lat, exp, elat);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] v0, got, exp;
    int          n = 0, lat;
    send(32'hFFFFFFC0, 32'd5, 1'b0, 1'b1, 32'hFFFFFFFE, 2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_shift: %b required 1", busy); end
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    v0 = resp_out;
    exp = exp_q.pop_front(); void'(lat_q.pop_front());
    checks++;
    if (resp_valid !== 1'b1 || v0 !== exp) begin
      errors++; $display("FAIL bp_first: vld=%b out=%h required 1/%h", resp_valid, v0, exp);
    end
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_in = $urandom; req_shamt = $urandom_range(0, 40);
      req_is_left = 1'($urandom); req_is_arith = 1'($urandom);
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_out !== v0 || req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: vld=%b out=%h rdy=%b busy=%b required 1/%h/0/1",
                 i, resp_valid, resp_out, req_ready, busy, v0);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
`ifdef SHIFT_SEQ_STATS_EN
    ops_done++;
`endif
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: vld=%b rdy=%b busy=%b required 0/1/0", resp_valid, req_ready, busy);
    end
    // A clean op straight after: nothing from the ignored requests leaked in.
    send(32'h0000F000, 32'd12, 1'b0, 1'b0, 32'h0000000F, 3);
    recv(got, lat);
    exp = exp_q.pop_front(); void'(lat_q.pop_front());
    checks++;
    if (got !== exp || lat !== 3 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_after: got %h/%0d required %h/3", got, lat, exp);
    end
`ifdef SHIFT_SEQ_STATS_EN
    checks++;
    if (op_count !== 16'(ops_done)) begin
      errors++; $display("FAIL opcount_total: %0d required %0d", op_count, ops_done);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] got, exp;
    int          lat, seen = 0;
    send(32'hFFFFFFC0, 32'd32, 1'b0, 1'b1, 32'hFFFFFFFF, 8);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete(); lat_q.delete();
    checks++;
    if ({req_ready, resp_valid, busy, resp_out} !== 35'h0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%b vld=%b busy=%b out=%h required all 0",
               req_ready, resp_valid, busy, resp_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_noresp: %0d response cycles required 0", seen); end
`ifdef SHIFT_SEQ_STATS_EN
    checks++;
    if (op_count !== 16'd0) begin errors++; $display("FAIL midreset_opcount: %0d required 0", op_count); end
    ops_done = 0;
`endif
    send(32'd6541, 32'd3, 1'b1, 1'b0, 32'd52328, 1);
    recv(got, lat);
    exp = exp_q.pop_front(); void'(lat_q.pop_front());
    checks++;
    if (got !== exp || lat !== 1) begin
      errors++; $display("FAIL midreset_next: got %h/%0d required %h/1", got, lat, exp);
    end
`ifdef SHIFT_SEQ_STATS_EN
    checks++;
    if (op_count !== 16'd1) begin errors++; $display("FAIL midreset_count1: %0d required 1", op_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
